// File: rtl/csla_frame_accumulator_if.sv
// Stream bundle for the frame accumulator: operand input stream and result output stream.
// The slave modport is the accumulator's view; the master modport is the producer/consumer side.
interface csla_frame_accumulator_if #(
    parameter int EXT_W = 4,
    parameter int CNT_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [15:0]         in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [16+EXT_W-1:0] out_data;
    logic [CNT_W-1:0]    out_count;
    logic                out_ovf;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/csla_frame_accumulator.sv
// Streaming frame accumulator built around a 16-bit carry-select adder whose upper
// blocks use a binary-to-excess-1 converter instead of a second ripple adder.
module modifiedcarry_adder (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    logic [4:0] blk0_s;
    logic [4:1] carry_s;

    assign blk0_s     = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]};
    assign sum_o[3:0] = blk0_s[3:0];
    assign carry_s[1] = blk0_s[4];

    for (genvar k = 1; k < 4; k++) begin : g_blk
        logic [4:0] rca_s;
        logic [4:0] bec_s;
        logic [4:0] sel_s;
        // Speculative cin=0 sum; the excess-1 copy stands in for the cin=1 adder.
        assign rca_s = {1'b0, a_i[4*k +: 4]} + {1'b0, b_i[4*k +: 4]};
        assign bec_s = rca_s + 5'd1;
        assign sel_s = carry_s[k] ? bec_s : rca_s;
        assign sum_o[4*k +: 4] = sel_s[3:0];
        if (k < 3) begin : g_carry
            assign carry_s[k+1] = sel_s[4];
        end else begin : g_cout
            assign cout_o = sel_s[4];
        end
    end
endmodule

module csla_frame_accumulator #(
    parameter int EXT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    csla_frame_accumulator_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        acc_lo_q, acc_lo_d;
    logic [EXT_W-1:0]   acc_hi_q, acc_hi_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        sum_s;
    logic               cout_s;
    logic               xfer_s;

    modifiedcarry_adder u_adder (
        .a_i    (acc_lo_q),
        .b_i    (bus.in_data),
        .sum_o  (sum_s),
        .cout_o (cout_s)
    );

    assign xfer_s        = bus.in_valid & bus.in_ready;
    assign bus.in_ready  = (state_q != DONE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = {acc_hi_q, acc_lo_q};
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;

    // Next-state and datapath update; clr outranks every handshake.
    always_comb begin
        state_d  = state_q;
        acc_lo_d = acc_lo_q;
        acc_hi_d = acc_hi_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (clr) begin
            state_d  = IDLE;
            acc_lo_d = 16'd0;
            acc_hi_d = {EXT_W{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (xfer_s) begin
                        acc_lo_d = sum_s;
                        acc_hi_d = acc_hi_q + {{(EXT_W-1){1'b0}}, cout_s};
                        ovf_d    = ovf_q | (cout_s & (&acc_hi_q));
                        if (cnt_q == {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q;
                        end else begin
                            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        if (bus.in_last) begin
                            state_d = DONE;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d  = IDLE;
                        acc_lo_d = 16'd0;
                        acc_hi_d = {EXT_W{1'b0}};
                        cnt_d    = {CNT_W{1'b0}};
                        ovf_d    = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    acc_lo_d = 16'd0;
                    acc_hi_d = {EXT_W{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    ovf_d    = 1'b0;
                end
            endcase
        end
    end

    // State and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_lo_q <= 16'd0;
            acc_hi_q <= {EXT_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_lo_q <= acc_lo_d;
            acc_hi_q <= acc_hi_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule
